// File: rtl/counter_pkg.sv
// +------------------------------------------------------------------+
// | counter_pkg: operation encoding shared by the counter datapath   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } cnt_op_e;

  // Enable dominates; load and count are mutually exclusive once enabled.
  function automatic cnt_op_e decode_op(input logic en, input logic load);
    if (!en) begin
      return OP_HOLD;
    end
    return load ? OP_LOAD : OP_COUNT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter.sv
// +------------------------------------------------------------------+
// | counter: up-counter with parallel load, fixed modular stride     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module counter #(
  parameter int          WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] o_addr
);

  import counter_pkg::*;

  // STEP is truncated to WIDTH bits, so the add wraps modulo 2^WIDTH.
  localparam logic [WIDTH-1:0] c_step = WIDTH'(STEP);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("counter: WIDTH must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] w_addr_next;
  cnt_op_e          w_op;

  always_comb begin
    w_op        = decode_op(i_en, i_load);
    w_addr_next = r_addr;
    case (w_op)
      OP_LOAD:  w_addr_next = i_addr;
      OP_COUNT: w_addr_next = r_addr + c_step;
      default:  w_addr_next = r_addr;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
    end else begin
      r_addr <= w_addr_next;
    end
  end

  assign o_addr = r_addr;

`ifndef SYNTHESIS
  a_ctrl_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !$isunknown({i_en, i_load}))
    else $error("counter: X on i_en/i_load out of reset");
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter.sv
// Scoreboard bench for counter (WIDTH=32, STEP=4): directed vectors queue
// their expected o_addr; monitors pop and compare after each rising edge.
`default_nettype none

module tb_counter;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_en    = 1'b0;
  logic        i_load  = 1'b0;
  logic [31:0] i_addr  = '0;
  logic [31:0] o_addr;

  counter #(.WIDTH(32), .STEP(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_load  (i_load),
    .i_addr  (i_addr),
    .o_addr  (o_addr)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] exp_q[$];
  logic [31:0] async_q[$];
  event        ev_async;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic compare(input string tag, input logic [31:0] exp);
    n_vec++;
    if (o_addr !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: o_addr=%h expected %h", tag, n_vec, o_addr, exp);
    end
  endtask

  // Synchronous monitor: one pending expectation per rising edge.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) compare("edge", exp_q.pop_front());
    end
  end

  // Asynchronous monitor: checks between edges after a reset pulse.
  initial begin
    forever begin
      @(ev_async);
      #1;
      if (async_q.size() > 0) compare("async_rst", async_q.pop_front());
    end
  end

  task automatic step(input logic en, input logic load,
                      input logic [31:0] addr, input logic [31:0] exp);
    @(negedge i_clk);
    i_en   = en;
    i_load = load;
    i_addr = addr;
    exp_q.push_back(exp);
  endtask

  initial begin
    // Reset held for two cycles, then released with i_en low.
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h5555_5555, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_q.push_back(32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // Load then count by 4 with no bubble.
    step(1'b1, 1'b1, 32'hDEEF_0000, 32'hDEEF_0000);
    step(1'b1, 1'b0, 32'h0, 32'hDEEF_0004);
    step(1'b1, 1'b0, 32'h0, 32'hDEEF_0008);
    step(1'b1, 1'b0, 32'h0, 32'hDEEF_000C);
    step(1'b1, 1'b0, 32'h0, 32'hDEEF_0010);
    step(1'b1, 1'b0, 32'h0, 32'hDEEF_0014);

    // Hold with i_load toggling and i_addr changing.
    step(1'b0, 1'b1, 32'h1111_1111, 32'hDEEF_0014);
    step(1'b0, 1'b0, 32'h2222_2222, 32'hDEEF_0014);
    step(1'b0, 1'b1, 32'h3333_3333, 32'hDEEF_0014);
    step(1'b0, 1'b0, 32'h4444_4444, 32'hDEEF_0014);
    step(1'b0, 1'b1, 32'h5555_5555, 32'hDEEF_0014);

    // Wrap through 2^32.
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 32'h0000_0000);
    step(1'b1, 1'b0, 32'h0, 32'h0000_0004);

    // Load priority, ignored load when disabled, X on i_addr while counting.
    step(1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678);
    step(1'b0, 1'b1, 32'hAAAA_AAAA, 32'h1234_5678);
    step(1'b1, 1'b0, 32'hxxxx_xxxx, 32'h1234_567C);
    step(1'b1, 1'b0, 32'h0, 32'h1234_5680);

    // Asynchronous reset pulse between rising edges while counting.
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    async_q.push_back(32'h0);
    -> ev_async;
    #3;
    i_rst_n = 1'b1;
    exp_q.push_back(32'h4);
    step(1'b1, 1'b0, 32'h0, 32'h8);
    step(1'b1, 1'b0, 32'h0, 32'hC);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && async_q.size() == 0) break;
      @(posedge i_clk);
      #2;
    end
    if (exp_q.size() != 0 || async_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0",
               exp_q.size() + async_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
